// File: rtl/wbc_pkg.sv
// Shared types and constants for the warm-boot controller.
// Optional feature macro: WBC_ARM_KEY_EN (arm-key gated grant).
package wbc_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_COUNT = 2'd1;
    localparam logic [1:0] ENC_SETUP = 2'd2;
    localparam logic [1:0] ENC_FIRE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_COUNT = ENC_COUNT,
        ST_SETUP = ENC_SETUP,
        ST_FIRE  = ENC_FIRE
    } wbc_state_t;

    localparam logic [7:0] ARM_KEY = 8'hA5;

    // Shift that turns the grace length into a visible LED blink period.
    function automatic int led_shift(input int cw);
        return (cw > 3) ? cw - 3 : 0;
    endfunction

endpackage

// File: rtl/wbc_prio_arb.sv
// Fixed-priority picker: lowest active index wins.
// Produces a one-hot vector, its index and an any-active flag.
module wbc_prio_arb
    import wbc_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    output logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // Scan from the top down so the lowest active bit is kept last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/warmboot_ctrl.sv
// Warm-boot request controller: arbitrate, grace countdown, setup, fire.
// Optional feature macro: WBC_ARM_KEY_EN (grant only with KEY == ARM_KEY).
module warmboot_ctrl
    import wbc_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int GRACE_CYCLES = 2**22,
    parameter int SETUP_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [2*NREQ-1:0] SEL,
    input  logic [7:0]        KEY,
    output logic [NREQ-1:0]   GNT,
    output logic              WB_S1,
    output logic              WB_S0,
    output logic              WB_BOOT,
    output logic              BUSY,
    output logic              LED,
    output logic              ERR
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(GRACE_CYCLES);
    localparam int SW   = $clog2(SETUP_CYCLES + 1);
    localparam int LB   = led_shift(CW);

    localparam logic [CW-1:0] CNT_LOAD = CW'(GRACE_CYCLES - 1);
    localparam logic [SW-1:0] SET_LOAD = SW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LED_MASK = CW'((1 << LB) - 1);

    wbc_state_t      state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   scnt;
    logic [NREQ-1:0] pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic [1:0]      sel_pick;
    logic            arm_ok;
    logic            led_tick;
    logic            gnt_held;

    wbc_prio_arb #(
        .N    (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req    (REQ),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel_pick = SEL[{pick_idx, 1'b0} +: 2];
    assign led_tick = ((cnt & LED_MASK) == '0);
    assign gnt_held = |(REQ & GNT);
    assign BUSY     = (state != ST_IDLE);

`ifdef WBC_ARM_KEY_EN
    logic err_q;

    assign arm_ok = (KEY == ARM_KEY);
    assign ERR    = err_q;

    // Sticky flag: a request arrived in IDLE with the wrong arm key.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (state == ST_IDLE && pick_any && !arm_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_key;

    assign unused_key = ^KEY;
    assign arm_ok     = 1'b1;
    assign ERR        = 1'b0;
`endif

    // Main FSM with registered grant, image select, boot strobe and LED.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            GNT     <= '0;
            WB_S1   <= 1'b0;
            WB_S0   <= 1'b0;
            WB_BOOT <= 1'b0;
            LED     <= 1'b0;
            cnt     <= '0;
            scnt    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_any && arm_ok) begin
                        state <= ST_COUNT;
                        GNT   <= pick_oh;
                        WB_S1 <= sel_pick[1];
                        WB_S0 <= sel_pick[0];
                        cnt   <= CNT_LOAD;
                        LED   <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (!gnt_held) begin
                        state <= ST_IDLE;
                        GNT   <= '0;
                        WB_S1 <= 1'b0;
                        WB_S0 <= 1'b0;
                        cnt   <= '0;
                        LED   <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= ST_SETUP;
                        scnt  <= SET_LOAD;
                        LED   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (led_tick) begin
                            LED <= ~LED;
                        end
                    end
                end
                ST_SETUP: begin
                    if (scnt == '0) begin
                        state   <= ST_FIRE;
                        WB_BOOT <= 1'b1;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                ST_FIRE: begin
                    WB_BOOT <= 1'b1;
                    LED     <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed bench for warmboot_ctrl (NREQ=4, GRACE=8, SETUP=4).
// Keyed-grant checks compile in when WBC_ARM_KEY_EN is defined.
module tb_warmboot_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic [7:0] SEL;
    logic [7:0] KEY;
    logic [3:0] GNT;
    logic       WB_S1;
    logic       WB_S0;
    logic       WB_BOOT;
    logic       BUSY;
    logic       LED;
    logic       ERR;

    int n_run  = 0;
    int n_fail = 0;

    warmboot_ctrl #(
        .NREQ         (4),
        .GRACE_CYCLES (8),
        .SETUP_CYCLES (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .SEL     (SEL),
        .KEY     (KEY),
        .GNT     (GNT),
        .WB_S1   (WB_S1),
        .WB_S0   (WB_S0),
        .WB_BOOT (WB_BOOT),
        .BUSY    (BUSY),
        .LED     (LED),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, ".gnt"},  GNT,     0);
        check({tag, ".boot"}, WB_BOOT, 0);
        check({tag, ".sel"},  {WB_S1, WB_S0}, 0);
        check({tag, ".led"},  LED,     0);
        check({tag, ".busy"}, BUSY,    0);
        check({tag, ".err"},  ERR,     0);
    endtask

    initial begin
        int  n;
        logic seen;

        RST = 1'b1;
        REQ = '0;
        SEL = '0;
`ifdef WBC_ARM_KEY_EN
        KEY = 8'hA5;
`else
        KEY = 8'h3C;
`endif
        step(2);
        check_idle_outs("reset");
        RST = 1'b0;
        step(1);

        // Single request from requester 2 with image 2'b10.
        SEL = 8'b00_10_00_00;
        REQ = 4'b0100;
        step(1);
        check("single.gnt",  GNT, 4'b0100);
        check("single.sel",  {WB_S1, WB_S0}, 2'b10);
        check("single.busy", BUSY, 1);
        check("single.led1", LED, 0);
        SEL = 8'b01_01_01_01;
        step(1);
        check("single.led2", LED, 1);
        step(1);
        check("single.led3", LED, 0);
        check("selchg.sel",  {WB_S1, WB_S0}, 2'b10);
        step(9);
        check("single.boot12", WB_BOOT, 0);
        check("single.setup_led", LED, 1);
        check("selchg.sel12", {WB_S1, WB_S0}, 2'b10);
        step(1);
        check("single.boot13", WB_BOOT, 1);
        step(5);
        check("single.boot_hold", WB_BOOT, 1);
        check("single.gnt_hold",  GNT, 4'b0100);
        check("single.sel_fire",  {WB_S1, WB_S0}, 2'b10);
        check("single.err", ERR, 0);

        // Asynchronous reset while in FIRE.
        #2 RST = 1'b1;
        #1 check_idle_outs("rstfire");
        #1 RST = 1'b0;
        #1 check("rstfire.nogrant", GNT, 0);
        REQ = '0;
        SEL = '0;
        step(2);

        // Contention: requesters 1 and 3 together.
        REQ  = 4'b1010;
        seen = 1'b0;
        step(1);
        check("cont.gnt", GNT, 4'b0010);
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (GNT[3]) seen = 1'b1;
        end
        check("cont.no_gnt3", seen, 0);
        check("cont.setup_led", LED, 1);
        check("cont.setup_busy", BUSY, 1);
        check("cont.setup_boot", WB_BOOT, 0);

        // Asynchronous reset in the middle of SETUP.
        #3 RST = 1'b1;
        #1 check_idle_outs("rstsetup");
        #1 RST = 1'b0;
        REQ = '0;
        step(2);

        // Cancel during COUNT, then restart with a full countdown.
        REQ = 4'b0001;
        step(1);
        check("cancel.gnt", GNT, 4'b0001);
        step(4);
        REQ = 4'b0000;
        step(1);
        check("cancel.busy", BUSY, 0);
        check("cancel.gnt0", GNT, 0);
        check("cancel.led",  LED, 0);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (WB_BOOT) seen = 1'b1;
        end
        check("cancel.noboot", seen, 0);
        REQ = 4'b0001;
        n = 0;
        while (!WB_BOOT && n < 40) begin
            step(1);
            n++;
        end
        check("restart.latency", n, 13);

        RST = 1'b1;
        step(1);
        RST = 1'b0;
        REQ = '0;
        step(1);

`ifdef WBC_ARM_KEY_EN
        // Wrong key blocks the grant and sets the sticky error.
        KEY = 8'h00;
        REQ = 4'b0001;
        step(1);
        check("key.nogrant", GNT, 0);
        check("key.err", ERR, 1);
        check("key.idle", BUSY, 0);
        KEY = 8'hA5;
        step(1);
        check("key.grant", GNT, 4'b0001);
        check("key.err_sticky", ERR, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/warmboot_ctrl.md
WARMBOOT_CTRL -- requirements
Module: warmboot_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 1..8.
REQ-002 Parameter GRACE_CYCLES, default 2**22: cancellable countdown length in cycles, minimum 2.
REQ-003 Parameter SETUP_CYCLES, default 16: image-select setup time before BOOT, in cycles, minimum 1.
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RST  in  1  reset; asynchronous, active-high.
REQ-006 REQ  in  NREQ  per-requester reboot request, level, held until granted or abandoned.
REQ-007 SEL  in  2*NREQ  per-requester image index; SEL[2i+1:2i] belongs to REQ[i].
REQ-008 KEY  in  8  arm key; used only under WBC_ARM_KEY_EN, otherwise ignored.
REQ-009 GNT  out  NREQ  one-hot grant, or all zero.
REQ-010 WB_S1, WB_S0  out  1 each  image select to the SB_WARMBOOT primitive.
REQ-011 WB_BOOT  out  1  boot strobe to the SB_WARMBOOT primitive.
REQ-012 BUSY  out  1  high in any state other than IDLE.
REQ-013 LED  out  1  status indicator.
REQ-014 ERR  out  1  sticky bad-key flag.

Function
REQ-015 States: IDLE, COUNT, SETUP, FIRE; exactly one state is active each cycle.
REQ-016 IDLE with any REQ bit high: the lowest-index active requester i wins; next cycle state=COUNT, GNT=1<<i, {WB_S1,WB_S0} latched from SEL[2i+1:2i].
REQ-017 Simultaneous requests: fixed priority, lowest index wins; losers receive no grant and are reconsidered only after a return to IDLE.
REQ-018 COUNT: a down-counter loads GRACE_CYCLES-1 on entry; when the counter reaches 0, next state=SETUP.
REQ-019 COUNT cancel: if REQ[granted] is low in any COUNT cycle, next cycle state=IDLE, GNT=0 and the counter clears; a cancel takes precedence over the terminal count in the same cycle.
REQ-020 SEL changes after the grant SHALL be ignored; WB_S1/WB_S0 stay stable from COUNT entry through FIRE.
REQ-021 SETUP: lasts exactly SETUP_CYCLES cycles, cannot be cancelled, then goes to FIRE.
REQ-022 FIRE: WB_BOOT=1 and held until reset, since the device reconfigures; no exit transition; GNT is held.
REQ-023 WB_BOOT is registered and is low in every state except FIRE.
REQ-024 LED: low in IDLE; in COUNT, toggles every 2**(log2(GRACE_CYCLES)-3) cycles, giving a visible blink; high in SETUP and FIRE.
REQ-025 Latency from REQ rise in IDLE to WB_BOOT rise is exactly 1+GRACE_CYCLES+SETUP_CYCLES cycles.

Reset
REQ-026 RST asserted at any time, including mid-COUNT or in FIRE, forces state=IDLE, GNT=0, WB_BOOT=0, WB_S1=WB_S0=0, LED=0, BUSY=0, ERR=0 and counters=0, without waiting for a clock edge.
REQ-027 After RST deasserts, the first grant occurs no earlier than the first rising CLK edge.

Configuration
REQ-028 Macro WBC_ARM_KEY_EN defined: the grant in REQ-016 occurs only if KEY==8'hA5 in the acceptance cycle; otherwise the state stays IDLE, ERR is set sticky until reset, and the request is re-evaluated each cycle.
REQ-029 Macro WBC_ARM_KEY_EN undefined: KEY is ignored and ERR is tied to 0.

Structure
REQ-030 Package wbc_pkg SHALL hold the state enum type, the ARM_KEY constant 8'hA5 and the state encodings.
REQ-031 One sub-module, wbc_prio_arb, SHALL provide the fixed-priority one-hot picker (REQ vector to one-hot vector plus index); the FSM, counters and outputs stay in warmboot_ctrl.

Verification (bench parameters: NREQ=4, GRACE_CYCLES=8, SETUP_CYCLES=4)
REQ-032 Single request: REQ=4'b0100, SEL[5:4]=2'b10, held -> GNT=4'b0100 at cycle 1, WB_S1=1 and WB_S0=0 from cycle 1, WB_BOOT rises at cycle 13 and stays high.
REQ-033 Contention: REQ=4'b1010 in the same cycle -> GNT=4'b0010; REQ[3] is never granted before reset.
REQ-034 Cancel: REQ[0] dropped at COUNT cycle 5 -> IDLE next cycle, GNT=0, WB_BOOT never rises; a new REQ[0] then restarts the full countdown.
REQ-035 Reset mid-SETUP: RST pulses asynchronously between edges -> all outputs 0 immediately, state=IDLE.
REQ-036 SEL changed during COUNT -> WB_S1 and WB_S0 unchanged.
REQ-037 With WBC_ARM_KEY_EN: KEY=8'h00 with REQ=4'b0001 -> no grant and ERR=1; KEY=8'hA5 -> grant next cycle, ERR remains 1.
